// File: rtl/toy_pack.sv
// Shared types and constants for the BPU predecode-filter flush sequencer.
package toy_pack;

    // Flush sequencer states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        RESUME = 2'd3
    } bpu_flush_state_e;

    // Maximum ICache fetches that may be in flight at once
    localparam int BPU_MAX_OUTSTANDING = 8;

endpackage : toy_pack

// File: rtl/bpu_outstanding_cnt.sv
// Up/down counter of in-flight ICache fetches, saturating at 0 and at MAX_OUTSTANDING.
module bpu_outstanding_cnt #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 full,
    output logic                 empty
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    assign full  = (cnt == CNT_MAX);
    assign empty = (cnt == '0);

    // Simultaneous inc and dec cancel; otherwise step without crossing either bound
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !empty) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule : bpu_outstanding_cnt

// File: rtl/bpu_filter_flush_ctrl.sv
// Sequences the BPU predecode filter across backend redirects: gates BTFIFO/ROB
// traffic to the filter, drops stale entries, clears the half-instruction carry,
// and reopens fetch only once no fetch is in flight and both producers are empty.
module bpu_filter_flush_ctrl
    import toy_pack::*;
#(
    parameter int MAX_OUTSTANDING = BPU_MAX_OUTSTANDING,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
    parameter int FLUSH_MIN_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fe_ctrl_be_chgflw_vld,
    input  logic                 icache_req_vld,
    output logic                 icache_req_rdy,
    input  logic                 btfifo_vld,
    output logic                 btfifo_rdy,
    input  logic                 rob_vld,
    output logic                 rob_rdy,
    output logic                 filt_btfifo_vld,
    input  logic                 filt_btfifo_rdy,
    output logic                 filt_rob_vld,
    input  logic                 filt_rob_rdy,
    output logic                 filt_last_clr,
    output logic                 ctrl_resume,
    output logic                 ctrl_busy,
    output logic [CNT_WIDTH-1:0] outstanding_cnt,
    output logic                 err_underflow
);

    // Timer only needs to hold FLUSH_MIN_CYC-1; keep at least one bit
    localparam int              TMR_W    = (FLUSH_MIN_CYC > 1) ? $clog2(FLUSH_MIN_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FLUSH_MIN_CYC - 1);

    bpu_flush_state_e state;
    logic [TMR_W-1:0] flush_tmr;
    logic             chgflw;
    logic             cnt_full;
    logic             cnt_empty;
    logic             req_fire;
    logic             rob_fire;
    logic             drain_done;

    assign chgflw     = fe_ctrl_be_chgflw_vld;
    assign req_fire   = icache_req_vld && icache_req_rdy;
    assign rob_fire   = rob_vld && rob_rdy;
    assign drain_done = cnt_empty && !rob_vld && !btfifo_vld;
    assign ctrl_busy  = (state != RUN);

    bpu_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_outstanding_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (req_fire),
        .dec   (rob_fire),
        .cnt   (outstanding_cnt),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    // Pass-through only in RUN with no redirect; otherwise accept-and-drop upstream
    always_comb begin
        filt_btfifo_vld = 1'b0;
        filt_rob_vld    = 1'b0;
        btfifo_rdy      = btfifo_vld;
        rob_rdy         = rob_vld;
        icache_req_rdy  = 1'b0;
        if (state == RUN && !chgflw) begin
            filt_btfifo_vld = btfifo_vld;
            filt_rob_vld    = rob_vld;
            btfifo_rdy      = filt_btfifo_rdy;
            rob_rdy         = filt_rob_rdy;
            icache_req_rdy  = !cnt_full;
        end
    end

    // Sticky flag: a ROB beat was accepted while no fetch was outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underflow <= 1'b0;
        end else if (rob_fire && cnt_empty) begin
            err_underflow <= 1'b1;
        end
    end

    // Flush FSM; carry-clear and resume pulse are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            flush_tmr     <= '0;
            ctrl_resume   <= 1'b0;
            filt_last_clr <= 1'b0;
        end else begin
            ctrl_resume   <= 1'b0;
            filt_last_clr <= 1'b0;
            if (chgflw) begin
                state         <= FLUSH;
                flush_tmr     <= TMR_LOAD;
                filt_last_clr <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        state <= RUN;
                    end
                    FLUSH: begin
                        if (flush_tmr == '0) begin
                            state <= DRAIN;
                        end else begin
                            flush_tmr     <= flush_tmr - 1'b1;
                            filt_last_clr <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (drain_done) begin
                            state       <= RESUME;
                            ctrl_resume <= 1'b1;
                        end
                    end
                    RESUME: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule : bpu_filter_flush_ctrl
